traffic_phase_fsm: RTL and testbench

- Phase sequencer that consumes the one-second enable pulse from the clock divider.
- Steps a two-road intersection (main road NS, side road EW) through green / yellow / all-red phases.
- Each phase lasts a parameterised number of one-second ticks.
- Main road rests in green; the side road is served only on vehicle-sensor or pedestrian demand.
- Also drives the divider's reset so that second boundaries align with phase start after system reset.

---
 rtl/traffic_pkg.sv | 35 +++
 rtl/traffic_phase_fsm_if.sv | 24 ++
 rtl/phase_timer.sv | 36 +++
 rtl/traffic_phase_fsm.sv | 107 ++++++++++
 tb/tb_traffic_phase_fsm.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared phase encodings, light codes and light decode helpers for the
// intersection phase sequencer.
package traffic_pkg;

  typedef enum logic [2:0] {
    STARTUP   = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALL_RED_1 = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    ALL_RED_2 = 3'd6
  } phase_e;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  function automatic logic [2:0] ns_light(phase_e p);
    case (p)
      NS_GREEN:  return LIGHT_GRN;
      NS_YELLOW: return LIGHT_YEL;
      default:   return LIGHT_RED;
    endcase
  endfunction

  function automatic logic [2:0] ew_light(phase_e p);
    case (p)
      EW_GREEN:  return LIGHT_GRN;
      EW_YELLOW: return LIGHT_YEL;
      default:   return LIGHT_RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_fsm_if.sv
// Sensor, tick and lamp signals between the phase sequencer and its
// surroundings (divider, sensors, lamp drivers).
interface traffic_phase_fsm_if;

  logic       tick_en;
  logic       car_sensor_ew;
  logic       ped_request;
  logic       divider_reset;
  logic [2:0] ns_lights;
  logic [2:0] ew_lights;
  logic       walk;
  logic [2:0] phase;

  modport master (
    output tick_en, car_sensor_ew, ped_request,
    input  divider_reset, ns_lights, ew_lights, walk, phase
  );

  modport slave (
    input  tick_en, car_sensor_ew, ped_request,
    output divider_reset, ns_lights, ew_lights, walk, phase
  );

endinterface

// File: rtl/phase_timer.sv
// Seconds counter for the current phase: clears on phase entry, counts
// ticks, and holds at duration-1 where done is raised.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_en_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] duration_i,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q, count_d;

  assign done_o = (count_q == duration_i - 1'b1);

  // Holding at the terminal count gives the main-road green its saturation.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (tick_en_i && !done_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/traffic_phase_fsm.sv
// Two-road intersection phase sequencer: main road rests green, side road
// is served on vehicle or pedestrian demand. All outputs are registered.
module traffic_phase_fsm
  import traffic_pkg::*;
#(
  parameter int GREEN_SECS     = 10,
  parameter int MIN_GREEN_SECS = 5,
  parameter int YELLOW_SECS    = 3,
  parameter int ALL_RED_SECS   = 1,
  parameter int CNT_W          = 8
) (
  input logic          clk,
  input logic          reset,
  traffic_phase_fsm_if.slave bus
);

  phase_e           state_q, state_d;
  logic             ped_pending_q, ped_pending_d;
  logic             walk_granted_q, walk_granted_d;
  logic [2:0]       ns_lights_q, ns_lights_d;
  logic [2:0]       ew_lights_q, ew_lights_d;
  logic             walk_q, walk_d;
  logic             divider_reset_q;
  logic [CNT_W-1:0] duration;
  logic             timer_done;
  logic             tick_done;
  logic             demand;
  logic             ew_entry;

  assign tick_done = bus.tick_en && timer_done;
  assign demand    = bus.car_sensor_ew | ped_pending_q | bus.ped_request;
  assign ew_entry  = (state_d == EW_GREEN) && (state_q != EW_GREEN);

  // Main-road green uses the minimum green as its timer length.
  always_comb begin
    case (state_q)
      NS_GREEN:             duration = CNT_W'(MIN_GREEN_SECS);
      NS_YELLOW, EW_YELLOW: duration = CNT_W'(YELLOW_SECS);
      EW_GREEN:             duration = CNT_W'(GREEN_SECS);
      default:              duration = CNT_W'(ALL_RED_SECS);
    endcase
  end

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .tick_en_i  (bus.tick_en),
    .clear_i    (state_d != state_q),
    .duration_i (duration),
    .done_o     (timer_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= STARTUP;
      ped_pending_q   <= 1'b0;
      walk_granted_q  <= 1'b0;
      ns_lights_q     <= LIGHT_RED;
      ew_lights_q     <= LIGHT_RED;
      walk_q          <= 1'b0;
      divider_reset_q <= 1'b1;
    end else begin
      state_q         <= state_d;
      ped_pending_q   <= ped_pending_d;
      walk_granted_q  <= walk_granted_d;
      ns_lights_q     <= ns_lights_d;
      ew_lights_q     <= ew_lights_d;
      walk_q          <= walk_d;
      divider_reset_q <= 1'b0;
    end
  end

  // Encoding 7 is unreachable but recovers through STARTUP if ever seen.
  always_comb begin
    state_d = state_q;
    case (state_q)
      STARTUP:   if (tick_done)           state_d = NS_GREEN;
      NS_GREEN:  if (tick_done && demand) state_d = NS_YELLOW;
      NS_YELLOW: if (tick_done)           state_d = ALL_RED_1;
      ALL_RED_1: if (tick_done)           state_d = EW_GREEN;
      EW_GREEN:  if (tick_done)           state_d = EW_YELLOW;
      EW_YELLOW: if (tick_done)           state_d = ALL_RED_2;
      ALL_RED_2: if (tick_done)           state_d = NS_GREEN;
      default:                            state_d = STARTUP;
    endcase
  end

  // A request in the same cycle as the EW_GREEN entry is consumed by the grant.
  always_comb begin
    ped_pending_d  = ped_pending_q | bus.ped_request;
    walk_granted_d = walk_granted_q;
    if (ew_entry) begin
      walk_granted_d = ped_pending_q | bus.ped_request;
      ped_pending_d  = 1'b0;
    end
    ns_lights_d = ns_light(state_d);
    ew_lights_d = ew_light(state_d);
    walk_d      = (state_d == EW_GREEN) && walk_granted_d;
  end

  assign bus.divider_reset = divider_reset_q;
  assign bus.ns_lights     = ns_lights_q;
  assign bus.ew_lights     = ew_lights_q;
  assign bus.walk          = walk_q;
  assign bus.phase         = state_q;

endmodule

// File: tb/tb_traffic_phase_fsm.sv
// Directed self-checking bench for traffic_phase_fsm with short phase
// durations and a tick every fourth clock.
module tb_traffic_phase_fsm;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam int DWELL [7] = '{1, 3, 2, 1, 4, 2, 1};

  logic clk = 1'b0;
  logic reset;
  bit   inv_en = 1'b0;
  int   errors = 0;
  int   checks = 0;

  traffic_phase_fsm_if bus();

  traffic_phase_fsm #(
    .GREEN_SECS     (4),
    .MIN_GREEN_SECS (3),
    .YELLOW_SECS    (2),
    .ALL_RED_SECS   (1),
    .CNT_W          (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Both roads must never show non-red at the same time.
  always @(negedge clk) begin
    if (inv_en) begin
      checks++;
      if (bus.ns_lights !== RED && bus.ew_lights !== RED) begin
        errors++;
        $display("[TB] FAIL invariant: ns=%b ew=%b, one of them must be %b", bus.ns_lights, bus.ew_lights, RED);
      end
    end
  end

  task automatic one_tick();
    for (int i = 0; i < 4; i++) begin
      bus.tick_en = (i == 3);
      @(posedge clk); #1;
    end
    bus.tick_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.tick_en = 1'b0;
    bus.ped_request = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic ped_pulse();
    bus.ped_request = 1'b1;
    @(posedge clk); #1;
    bus.ped_request = 1'b0;
  endtask

  // Ticks spent in the current phase, and samples within it showing walk.
  task automatic measure(output int n, output int w);
    logic [2:0] start;
    start = bus.phase;
    n = 0;
    w = (bus.walk === 1'b1) ? 1 : 0;
    while (bus.phase === start && n < 40) begin
      one_tick();
      n++;
      if (bus.phase === start && bus.walk === 1'b1) w++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.tick_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.tick_en = 1'b0;
    checks++;
    if (bus.phase !== 3'd0 || bus.ns_lights !== RED || bus.ew_lights !== RED || bus.walk !== 1'b0 || bus.divider_reset !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_values: phase=%0d ns=%b ew=%b walk=%b div=%b, want 0 100 100 0 1", bus.phase, bus.ns_lights, bus.ew_lights, bus.walk, bus.divider_reset);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.divider_reset !== 1'b1) begin
      errors++;
      $display("[TB] FAIL div_before_edge: got %b want 1", bus.divider_reset);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.divider_reset !== 1'b0 || bus.phase !== 3'd0) begin
      errors++;
      $display("[TB] FAIL div_after_edge: div=%b phase=%0d want 0 0", bus.divider_reset, bus.phase);
    end
    one_tick();
    checks++;
    if (bus.phase !== 3'd1) begin
      errors++;
      $display("[TB] FAIL startup_exit: phase=%0d want 1", bus.phase);
    end
    for (int t = 0; t < 20; t++) begin
      one_tick();
      checks++;
      if (bus.phase !== 3'd1 || bus.ns_lights !== GRN || bus.ew_lights !== RED || bus.divider_reset !== 1'b0) begin
        errors++;
        $display("[TB] FAIL ns_rest tick %0d: phase=%0d ns=%b ew=%b div=%b want 1 001 100 0", t, bus.phase, bus.ns_lights, bus.ew_lights, bus.divider_reset);
      end
    end
  endtask

  task automatic test_car_demand();
    int n, w;
    logic [2:0] ph;
    bus.car_sensor_ew = 1'b1;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      ph = bus.phase;
      measure(n, w);
      checks++;
      if (ph !== 3'(k) || n !== DWELL[k] || w !== 0) begin
        errors++;
        $display("[TB] FAIL car_cycle step %0d: phase=%0d ticks=%0d walk=%0d want %0d %0d 0", k, ph, n, w, k, DWELL[k]);
      end
    end
    checks++;
    if (bus.phase !== 3'd1 || bus.ns_lights !== GRN) begin
      errors++;
      $display("[TB] FAIL car_return: phase=%0d ns=%b want 1 001", bus.phase, bus.ns_lights);
    end
    bus.car_sensor_ew = 1'b0;
  endtask

  task automatic test_ped_ns();
    int n, w;
    logic [2:0] ph;
    bus.car_sensor_ew = 1'b0;
    do_reset();
    measure(n, w);
    ped_pulse();
    for (int k = 1; k < 7; k++) begin
      ph = bus.phase;
      measure(n, w);
      checks++;
      if (ph !== 3'(k) || n !== DWELL[k] || w !== ((k == 4) ? 4 : 0)) begin
        errors++;
        $display("[TB] FAIL ped_ns step %0d: phase=%0d ticks=%0d walk=%0d want %0d %0d %0d", k, ph, n, w, k, DWELL[k], (k == 4) ? 4 : 0);
      end
    end
    checks++;
    if (dut.ped_pending_q !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ped_cleared: pending=%b want 0", dut.ped_pending_q);
    end
    repeat (5) one_tick();
    checks++;
    if (bus.phase !== 3'd1 || bus.walk !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ped_ns_rest: phase=%0d walk=%b want 1 0", bus.phase, bus.walk);
    end
  endtask

  task automatic test_ped_ew();
    int n, w;
    logic [2:0] ph;
    int seq_ph [6] = '{5, 6, 1, 2, 3, 4};
    int seq_n  [6] = '{2, 1, 3, 2, 1, 4};
    int seq_w  [6] = '{0, 0, 0, 0, 0, 4};
    bus.car_sensor_ew = 1'b1;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      ph = bus.phase;
      measure(n, w);
      checks++;
      if (ph !== 3'(k) || n !== DWELL[k] || w !== 0) begin
        errors++;
        $display("[TB] FAIL ped_ew_first step %0d: phase=%0d ticks=%0d walk=%0d want %0d %0d 0", k, ph, n, w, k, DWELL[k]);
      end
    end
    bus.car_sensor_ew = 1'b0;
    ped_pulse();
    for (int k = 0; k < 6; k++) begin
      ph = bus.phase;
      measure(n, w);
      checks++;
      if (ph !== 3'(seq_ph[k]) || n !== seq_n[k] || w !== seq_w[k]) begin
        errors++;
        $display("[TB] FAIL ped_ew_next step %0d: phase=%0d ticks=%0d walk=%0d want %0d %0d %0d", k, ph, n, w, seq_ph[k], seq_n[k], seq_w[k]);
      end
    end
  endtask

  task automatic test_late_demand();
    bus.car_sensor_ew = 1'b0;
    do_reset();
    repeat (7) one_tick();
    checks++;
    if (bus.phase !== 3'd1) begin
      errors++;
      $display("[TB] FAIL late_rest: phase=%0d want 1", bus.phase);
    end
    bus.car_sensor_ew = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.phase !== 3'd1) begin
        errors++;
        $display("[TB] FAIL late_no_early cycle %0d: phase=%0d want 1", i, bus.phase);
      end
    end
    bus.tick_en = 1'b1;
    @(posedge clk); #1;
    bus.tick_en = 1'b0;
    checks++;
    if (bus.phase !== 3'd2 || bus.ns_lights !== YEL) begin
      errors++;
      $display("[TB] FAIL late_yellow: phase=%0d ns=%b want 2 010", bus.phase, bus.ns_lights);
    end
    bus.car_sensor_ew = 1'b0;
  endtask

  task automatic test_mid_reset();
    int n, w;
    bus.car_sensor_ew = 1'b1;
    do_reset();
    measure(n, w);
    ped_pulse();
    repeat (3) measure(n, w);
    checks++;
    if (bus.phase !== 3'd4 || bus.ew_lights !== GRN || bus.walk !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_ew_green: phase=%0d ew=%b walk=%b want 4 001 1", bus.phase, bus.ew_lights, bus.walk);
    end
    one_tick();
    ped_pulse();
    bus.car_sensor_ew = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.ns_lights !== RED || bus.ew_lights !== RED || bus.walk !== 1'b0 || bus.phase !== 3'd0 || bus.divider_reset !== 1'b1 || dut.ped_pending_q !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_async: ns=%b ew=%b walk=%b phase=%0d div=%b pend=%b want 100 100 0 0 1 0", bus.ns_lights, bus.ew_lights, bus.walk, bus.phase, bus.divider_reset, dut.ped_pending_q);
    end
    @(posedge clk); #1 reset = 1'b0;
    measure(n, w);
    checks++;
    if (n !== 1 || bus.phase !== 3'd1) begin
      errors++;
      $display("[TB] FAIL mid_restart: startup ticks=%0d phase=%0d want 1 1", n, bus.phase);
    end
    repeat (5) one_tick();
    checks++;
    if (bus.phase !== 3'd1 || bus.walk !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_request_lost: phase=%0d walk=%b want 1 0", bus.phase, bus.walk);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.tick_en = 1'b0;
    bus.car_sensor_ew = 1'b0;
    bus.ped_request = 1'b0;
    @(posedge clk); #1;
    inv_en = 1'b1;
    test_reset();
    test_car_demand();
    test_ped_ns();
    test_ped_ew();
    test_late_demand();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
